// File: rtl/telemetry_stack_scheduler.sv
// Round-robin framer: shares one byte link between the G, M and P sensor stacks, one 13-byte frame per served source.
// Latency: tick pulse to first TX_VALID is 2 edges; a frame costs 1 ARB cycle plus 13 byte transfers.
// Backpressure: the FSM advances only on TX_VALID & TX_READY; TX_DATA is held while the sink stalls.
module telemetry_stack_scheduler #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] ID_G      = 8'h01,
  parameter logic [7:0] ID_M      = 8'h02,
  parameter logic [7:0] ID_P      = 8'h03
) (
  input  logic        CLK_100KHZ,
  input  logic        RESET,
  input  logic        CLK_10HZ,
  input  logic [2:0]  SRC_EN,
  input  logic [79:0] G_DATA_STACK,
  input  logic [79:0] M_DATA_STACK,
  input  logic [79:0] P_DATA_STACK,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic [2:0]  GRANT,
  output logic        BUSY,
  output logic [2:0]  OVERRUN
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SYNC, S_ID, S_DATA, S_CSUM
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;       // [0]=s1, [1]=s2, [2]=s3 (edge detect)
  logic [2:0]  pending_q, pending_d;
  logic [2:0]  overrun_q, overrun_d;
  logic [1:0]  ptr_q, ptr_d;         // index of the last source served
  logic [79:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [2:0]  grant_q, grant_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;

  logic        tick;
  logic [2:0]  tick_set;
  logic [2:0]  serving;
  logic [1:0]  cand1, cand2, sel;
  logic        pend_any;
  logic        tx_fire;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic [7:0] id_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return ID_G;
      2'd1:    return ID_M;
      default: return ID_P;
    endcase
  endfunction

  // Tick detection, arbitration and pending/overrun bookkeeping
  always_comb begin
    sync_d   = {sync_q[1:0], CLK_10HZ};
    tick     = sync_q[1] & ~sync_q[2];
    tick_set = tick ? SRC_EN : 3'b000;

    cand1 = inc3(ptr_q);
    cand2 = inc3(cand1);
    if (pending_q[cand1])      sel = cand1;
    else if (pending_q[cand2]) sel = cand2;
    else                       sel = ptr_q;

    // A bit being served in ARB is cleared, so a colliding tick re-arms it without an overrun
    serving   = (state_q == S_ARB) ? (3'b001 << sel) : 3'b000;
    overrun_d = overrun_q | (tick_set & pending_q & ~serving);
    pending_d = (pending_q & ~serving) | tick_set;
    // Include this cycle's tick so IDLE/CSUM can jump to ARB on the same edge the bit is set
    pend_any  = (pending_q | tick_set) != 3'b000;
    tx_fire   = tx_valid_q & TX_READY;
  end

  // Frame sequencing: next state, shift register, checksum and registered outputs
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      S_IDLE: begin
        if (pend_any) state_d = S_ARB;
      end
      S_ARB: begin
        case (sel)
          2'd0:    shreg_d = G_DATA_STACK;
          2'd1:    shreg_d = M_DATA_STACK;
          default: shreg_d = P_DATA_STACK;
        endcase
        grant_d    = 3'b001 << sel;
        ptr_d      = sel;
        csum_d     = id_of(sel);
        tx_data_d  = SYNC_BYTE;
        tx_valid_d = 1'b1;
        state_d    = S_SYNC;
      end
      S_SYNC: begin
        if (tx_fire) begin
          tx_data_d = id_of(ptr_q);
          state_d   = S_ID;
        end
      end
      S_ID: begin
        if (tx_fire) begin
          tx_data_d = shreg_q[79:72];
          csum_d    = csum_q ^ shreg_q[79:72];
          shreg_d   = {shreg_q[71:0], 8'h00};
          cnt_d     = 4'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_fire) begin
          if (cnt_q == 4'd9) begin
            // csum_q already folds in the tenth byte, which was XORed when it was loaded
            tx_data_d = csum_q;
            state_d   = S_CSUM;
          end else begin
            tx_data_d = shreg_q[79:72];
            csum_d    = csum_q ^ shreg_q[79:72];
            shreg_d   = {shreg_q[71:0], 8'h00};
            cnt_d     = cnt_q + 4'd1;
          end
        end
      end
      S_CSUM: begin
        if (tx_fire) begin
          grant_d    = 3'b000;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
          state_d    = pend_any ? S_ARB : S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        grant_d    = 3'b000;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // All state registers; reset abandons any frame in flight
  always_ff @(posedge CLK_100KHZ or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      sync_q     <= 3'b000;
      pending_q  <= 3'b000;
      overrun_q  <= 3'b000;
      ptr_q      <= 2'd2;
      shreg_q    <= 80'h0;
      cnt_q      <= 4'd0;
      csum_q     <= 8'h00;
      grant_q    <= 3'b000;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      ptr_q      <= ptr_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_DATA  = tx_data_q;
  assign TX_VALID = tx_valid_q;
  assign GRANT    = grant_q;
  assign BUSY     = busy_q;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_telemetry_stack_scheduler.sv
// Directed bench for telemetry_stack_scheduler: single frame, round-robin, backpressure, overrun, disable, reset.
// Checks every transferred byte against a bench-side frame model and hand-computed constants.
// Byte transfers are collected at the rising edge; stalled bytes are checked for stability.
module tb_telemetry_stack_scheduler;

  logic        clk;
  logic        rst_n;
  logic        clk_10hz;
  logic [2:0]  src_en;
  logic [79:0] g_stack, m_stack, p_stack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  grant;
  logic        busy;
  logic [2:0]  overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] rx_q[$];   // {GRANT, TX_DATA} per transfer

  localparam logic [79:0] G_VAL = 80'h0123456789ABCDEF1122;
  localparam logic [79:0] M_VAL = 80'hFEDCBA98765432100F0E;
  localparam logic [79:0] P_VAL = 80'h55AA3C3CC3C30000FFFF;

  telemetry_stack_scheduler dut (
    .CLK_100KHZ  (clk),
    .RESET       (rst_n),
    .CLK_10HZ    (clk_10hz),
    .SRC_EN      (src_en),
    .G_DATA_STACK(g_stack),
    .M_DATA_STACK(m_stack),
    .P_DATA_STACK(p_stack),
    .TX_DATA     (tx_data),
    .TX_VALID    (tx_valid),
    .TX_READY    (tx_ready),
    .GRANT       (grant),
    .BUSY        (busy),
    .OVERRUN     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transfer collector and stall-stability monitor
  initial begin
    logic       hold_vld;
    logic [7:0] hold_dat;
    logic [2:0] hold_g;
    hold_vld = 1'b0;
    hold_dat = 8'h00;
    hold_g   = 3'b000;
    forever begin
      @(posedge clk);
      if (rst_n === 1'b1) begin
        if (hold_vld)
          chk("stall_hold", {21'd0, tx_valid, grant, tx_data}, {21'd0, 1'b1, hold_g, hold_dat});
        if (tx_valid === 1'b1 && tx_ready === 1'b1)
          rx_q.push_back({grant, tx_data});
        hold_vld = (tx_valid === 1'b1) && (tx_ready === 1'b0);
        hold_dat = tx_data;
        hold_g   = grant;
      end else begin
        hold_vld = 1'b0;
      end
    end
  end

  function automatic logic [7:0] model_byte(input logic [7:0] id, input logic [79:0] st, input int k);
    logic [7:0] cs;
    if (k == 0) return 8'hA5;
    if (k == 1) return id;
    if (k <= 11) return st[79 - 8*(k-2) -: 8];
    cs = id;
    for (int j = 0; j < 10; j++) cs = cs ^ st[79 - 8*j -: 8];
    return cs;
  endfunction

  task automatic check_frame(input string tag, input logic [2:0] g, input logic [7:0] id,
                             input logic [79:0] st);
    logic [10:0] got;
    for (int k = 0; k < 13; k++) begin
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 11'h7FF;
      chk($sformatf("%s_b%0d", tag, k), {21'd0, got}, {21'd0, g, model_byte(id, st, k)});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    clk_10hz = 1'b0;
    repeat (3) @(negedge clk);
    rx_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    clk_10hz = 1'b1;
    repeat (3) @(negedge clk);
    clk_10hz = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget, input bit bp);
    int cyc;
    cyc = 0;
    while (rx_q.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bp) tx_ready = ((cyc / 3) % 2) == 1;
    end
    if (bp) tx_ready = 1'b1;
    chk({tag, "_timeout"}, (rx_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while (tx_valid !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_valid_timeout"}, {31'd0, tx_valid}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while (busy !== 1'b0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [7:0] exp1 [13];
    exp1 = '{8'hA5, 8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
             8'h11, 8'h22, 8'h32};
    rst_n    = 1'b0;
    clk_10hz = 1'b0;
    src_en   = 3'b000;
    g_stack  = G_VAL;
    m_stack  = M_VAL;
    p_stack  = P_VAL;
    tx_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
    chk("rst_grant",    {29'd0, grant},    32'd0);
    chk("rst_busy",     {31'd0, busy},     32'd0);
    chk("rst_overrun",  {29'd0, overrun},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single source, hand-computed bytes
    src_en   = 3'b001;
    tx_ready = 1'b1;
    tick();
    wait_bytes("single", 13, 200, 1'b0);
    for (int k = 0; k < 13; k++) begin
      logic [10:0] got;
      got = (rx_q.size() > 0) ? rx_q.pop_front() : 11'h7FF;
      chk($sformatf("single_b%0d", k), {21'd0, got}, {21'd0, 3'b001, exp1[k]});
    end
    wait_idle("single", 50);
    chk("single_overrun", {29'd0, overrun}, 32'd0);

    // Round-robin: three ticks, each serves G, M, P
    do_reset();
    src_en   = 3'b111;
    tx_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      wait_bytes($sformatf("rr%0d", t), 39, 300, 1'b0);
      check_frame($sformatf("rr%0d_g", t), 3'b001, 8'h01, G_VAL);
      check_frame($sformatf("rr%0d_m", t), 3'b010, 8'h02, M_VAL);
      check_frame($sformatf("rr%0d_p", t), 3'b100, 8'h03, P_VAL);
      wait_idle($sformatf("rr%0d", t), 50);
    end

    // Backpressure plus snapshot: input changes after ARB must not leak into the frame
    do_reset();
    src_en   = 3'b001;
    tx_ready = 1'b0;
    tick();
    wait_valid("bp", 50);
    g_stack = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    wait_bytes("bp", 13, 400, 1'b1);
    check_frame("bp", 3'b001, 8'h01, G_VAL);
    chk("bp_extra", rx_q.size(), 32'd0);
    g_stack = G_VAL;
    wait_idle("bp", 50);

    // Overrun: one frame stalled, then one tick re-arms pending, the next overflows it
    do_reset();
    src_en   = 3'b001;
    tx_ready = 1'b0;
    tick();
    wait_valid("ovr", 50);
    tick();
    chk("ovr_after_2", {29'd0, overrun}, 32'd0);
    tick();
    chk("ovr_after_3", {29'd0, overrun}, 32'b001);
    tx_ready = 1'b1;
    wait_bytes("ovr", 26, 300, 1'b0);
    check_frame("ovr_f1", 3'b001, 8'h01, G_VAL);
    check_frame("ovr_f2", 3'b001, 8'h01, G_VAL);
    wait_idle("ovr", 50);
    repeat (20) @(negedge clk);
    chk("ovr_no_third", rx_q.size(), 32'd0);
    chk("ovr_sticky", {29'd0, overrun}, 32'b001);

    // Disable mid-run: M stays pending after its enable drops
    do_reset();
    src_en   = 3'b011;
    tx_ready = 1'b0;
    tick();
    wait_valid("dis", 50);
    src_en   = 3'b001;
    tx_ready = 1'b1;
    wait_bytes("dis", 26, 300, 1'b0);
    check_frame("dis_g", 3'b001, 8'h01, G_VAL);
    check_frame("dis_m", 3'b010, 8'h02, M_VAL);
    wait_idle("dis", 50);
    tick();
    wait_bytes("dis2", 13, 200, 1'b0);
    check_frame("dis2_g", 3'b001, 8'h01, G_VAL);
    wait_idle("dis2", 50);
    repeat (20) @(negedge clk);
    chk("dis2_no_m", rx_q.size(), 32'd0);

    // Reset mid-frame with OVERRUN set beforehand
    do_reset();
    src_en   = 3'b001;
    tx_ready = 1'b0;
    tick();
    wait_valid("rmf", 50);
    tick();
    tick();
    chk("rmf_overrun_pre", {29'd0, overrun}, 32'b001);
    tx_ready = 1'b1;
    wait_bytes("rmf", 5, 100, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rmf_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rmf_grant",    {29'd0, grant},    32'd0);
    chk("rmf_overrun",  {29'd0, overrun},  32'd0);
    chk("rmf_busy",     {31'd0, busy},     32'd0);
    repeat (3) @(negedge clk);
    rx_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    tick();
    wait_bytes("rmf_next", 13, 200, 1'b0);
    check_frame("rmf_next", 3'b001, 8'h01, G_VAL);
    wait_idle("rmf_next", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
